i2s_tx_feeder: RTL and testbench

Stereo sample buffer directly upstream of the I2S transmitter, in the 12.288 MHz I2S clock domain. It accepts left/right sample pairs on a valid/ready stream and serves the transmitter's once-per-frame read request (rd_en -> rd_valid next cycle). It primes to a start threshold, plays silence on underrun, and counts underruns for status.

---
 rtl/i2s_tx_feeder_if.sv | 31 +++
 rtl/i2s_tx_feeder.sv | 131 +++++++++++++
 tb/tb_i2s_tx_feeder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_feeder_if
// Brief    : Sample-stream and transmitter-read bundle for i2s_tx_feeder
// Revision : 1.0 - initial release
// ============================================================================
interface i2s_tx_feeder_if #(
    parameter int DW = 24
);
    logic [DW-1:0] s_ldata;
    logic [DW-1:0] s_rdata;
    logic          s_valid;
    logic          s_ready;
    logic          rd_en;
    logic [DW-1:0] ldata;
    logic [DW-1:0] rdata;
    logic          rd_valid;

    // Upstream producer and I2S transmitter side
    modport master (
        output s_ldata, s_rdata, s_valid, rd_en,
        input  s_ready, ldata, rdata, rd_valid
    );

    // Buffer side
    modport slave (
        input  s_ldata, s_rdata, s_valid, rd_en,
        output s_ready, ldata, rdata, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/i2s_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_feeder
// Brief    : Stereo FIFO feeding an I2S transmitter; primes, plays silence on
//            underrun and keeps a saturating underrun count.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx_feeder #(
    parameter int DW          = 24,
    parameter int DEPTH       = 16,
    parameter int START_LEVEL = 8
) (
    input  wire                       clk,
    input  wire                       rst,
    i2s_tx_feeder_if.slave            bus,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      running,
    output logic                      underrun,
    output logic [15:0]               underrun_count,
    input  wire                       underrun_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [0:0] ST_PRIMING = 1'b0;
    localparam logic [0:0] ST_RUNNING = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [LW-1:0]   r_level;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [2*DW-1:0] r_mem [DEPTH];
    logic [DW-1:0]   r_ldata;
    logic [DW-1:0]   r_rdata;
    logic            r_rd_valid;
    logic            r_underrun;
    logic [15:0]     r_count;

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_urun;

    assign w_full      = (r_level == LW'(DEPTH));
    assign bus.s_ready = !rst && !w_full;
    assign w_push      = bus.s_valid && bus.s_ready;
    // Reads only drain the FIFO while RUNNING; an empty read there is an underrun
    assign w_pop  = !rst && bus.rd_en && (r_state == ST_RUNNING) && (r_level != '0);
    assign w_urun = !rst && bus.rd_en && (r_state == ST_RUNNING) && (r_level == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_PRIMING;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_PRIMING: if (r_level >= LW'(START_LEVEL)) w_state_nxt = ST_RUNNING;
            ST_RUNNING: if (w_urun) w_state_nxt = ST_PRIMING;
            default:    w_state_nxt = ST_PRIMING;
        endcase
    end

    always_comb begin
        running = (r_state == ST_RUNNING);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.s_ldata, bus.s_rdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ldata    <= '0;
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_en;
            r_underrun <= w_urun;
            if (w_pop) begin
                {r_ldata, r_rdata} <= r_mem[r_rptr];
            end else if (bus.rd_en) begin
                r_ldata <= '0;
                r_rdata <= '0;
            end
        end
    end

    // A clear that lands on an underrun still records that underrun
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (underrun_clr) begin
            r_count <= w_urun ? 16'd1 : 16'd0;
        end else if (w_urun && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign bus.ldata    = r_ldata;
    assign bus.rdata    = r_rdata;
    assign bus.rd_valid = r_rd_valid;
    assign level          = r_level;
    assign underrun       = r_underrun;
    assign underrun_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx_feeder
// Brief    : Directed self-checking bench for i2s_tx_feeder
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_feeder;
    localparam int DW = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  level;
    logic        running;
    logic        underrun;
    logic [15:0] underrun_count;
    logic        underrun_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    i2s_tx_feeder_if #(.DW(DW)) bus ();

    i2s_tx_feeder #(.DW(DW), .DEPTH(16), .START_LEVEL(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .level          (level),
        .running        (running),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .underrun_clr   (underrun_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.rd_en   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
        bus.s_ldata = l;
        bus.s_rdata = r;
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic read_pair();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [DW-1:0] l, input logic [DW-1:0] r);
        read_pair();
        chk({tag, "_vld"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, "_l"},   32'(bus.ldata), 32'(l));
        chk({tag, "_r"},   32'(bus.rdata), 32'(r));
    endtask

    initial begin
        bus.s_ldata = '0;
        bus.s_rdata = '0;
        bus.s_valid = 1'b0;
        bus.rd_en   = 1'b0;

        // Reset state, sampled while rst is still asserted
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ready",   32'(bus.s_ready), 32'd0);
        chk("rst_rdvalid", 32'(bus.rd_valid), 32'd0);
        chk("rst_level",   32'(level), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_count",   32'(underrun_count), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(bus.s_ready), 32'd1);

        // 1: prime with 8 pairs, then first read returns the head pair
        for (int i = 0; i < 8; i++) push(24'h010000 + 24'(i), 24'h020000 + 24'(i));
        chk("t1_level8",    32'(level), 32'd8);
        chk("t1_notyet",    32'(running), 32'd0);
        tick();
        chk("t1_running",   32'(running), 32'd1);
        read_chk("t1_rd", 24'h010000, 24'h020000);
        chk("t1_level7",    32'(level), 32'd7);
        tick();
        chk("t1_pulse_end", 32'(bus.rd_valid), 32'd0);
        chk("t1_hold_l",    32'(bus.ldata), 32'h010000);

        // 2: read while priming gives silence without popping
        do_reset();
        for (int i = 0; i < 3; i++) push(24'h0A0000 + 24'(i), 24'h0B0000 + 24'(i));
        read_chk("t2_rd", 24'h0, 24'h0);
        chk("t2_level",    32'(level), 32'd3);
        chk("t2_underrun", 32'(underrun), 32'd0);
        chk("t2_count",    32'(underrun_count), 32'd0);
        chk("t2_running",  32'(running), 32'd0);

        // 3: fill to full with s_valid held, 17th pair dropped
        do_reset();
        bus.s_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.s_ldata = 24'h000100 + 24'(i);
            bus.s_rdata = 24'h000200 + 24'(i);
            tick();
        end
        bus.s_valid = 1'b0;
        chk("t3_full_level", 32'(level), 32'd16);
        chk("t3_full_ready", 32'(bus.s_ready), 32'd0);
        chk("t3_running",    32'(running), 32'd1);
        read_chk("t3_rd0", 24'h000100, 24'h000200);
        chk("t3_level15",    32'(level), 32'd15);
        chk("t3_ready",      32'(bus.s_ready), 32'd1);
        for (int i = 1; i < 16; i++) read_chk("t3_rd", 24'h000100 + 24'(i), 24'h000200 + 24'(i));
        chk("t3_empty",      32'(level), 32'd0);
        read_chk("t3_urun", 24'h0, 24'h0);
        chk("t3_urun_flag",  32'(underrun), 32'd1);
        chk("t3_urun_count", 32'(underrun_count), 32'd1);
        chk("t3_urun_state", 32'(running), 32'd0);
        tick();
        chk("t3_urun_pulse", 32'(underrun), 32'd0);

        // 6: reset with rd_en high while running at level 10
        for (int i = 0; i < 10; i++) push(24'h000500 + 24'(i), 24'h000600 + 24'(i));
        tick();
        chk("t6_pre_level",   32'(level), 32'd10);
        chk("t6_pre_running", 32'(running), 32'd1);
        rst = 1'b1;
        bus.rd_en = 1'b1;
        tick();
        rst = 1'b0;
        bus.rd_en = 1'b0;
        #1;
        chk("t6_no_rdvalid", 32'(bus.rd_valid), 32'd0);
        chk("t6_level",      32'(level), 32'd0);
        chk("t6_running",    32'(running), 32'd0);
        chk("t6_count",      32'(underrun_count), 32'd0);
        chk("t6_ready",      32'(bus.s_ready), 32'd1);

        // 4: drain to level 1, then read twice with a long gap
        do_reset();
        for (int i = 0; i < 8; i++) push(24'h000700 + 24'(i), 24'h000800 + 24'(i));
        tick();
        for (int i = 0; i < 7; i++) read_chk("t4_drain", 24'h000700 + 24'(i), 24'h000800 + 24'(i));
        chk("t4_level1", 32'(level), 32'd1);
        read_chk("t4_last", 24'h000707, 24'h000807);
        chk("t4_no_urun", 32'(underrun), 32'd0);
        repeat (255) tick();
        read_chk("t4_urun", 24'h0, 24'h0);
        chk("t4_urun_flag",  32'(underrun), 32'd1);
        chk("t4_urun_count", 32'(underrun_count), 32'd1);
        chk("t4_running",    32'(running), 32'd0);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        chk("t4_clr", 32'(underrun_count), 32'd0);

        // 5: simultaneous push and pop at level 5
        do_reset();
        for (int i = 0; i < 8; i++) push(24'h000300 + 24'(i), 24'h000400 + 24'(i));
        tick();
        for (int i = 0; i < 3; i++) read_chk("t5_pre", 24'h000300 + 24'(i), 24'h000400 + 24'(i));
        chk("t5_level5", 32'(level), 32'd5);
        bus.s_ldata = 24'h000308;
        bus.s_rdata = 24'h000408;
        bus.s_valid = 1'b1;
        bus.rd_en   = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        bus.rd_en   = 1'b0;
        chk("t5_both_l",     32'(bus.ldata), 32'h000303);
        chk("t5_both_level", 32'(level), 32'd5);
        for (int i = 4; i < 9; i++) read_chk("t5_fifo", 24'h000300 + 24'(i), 24'h000400 + 24'(i));
        chk("t5_empty", 32'(level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
